// File: rtl/mm_wr_capture_pkg.sv
// Shared types and derived constants for the main-memory write capture engine.
// Optional circular buffer enabled by MM_WR_CAPTURE_WRAP_EN (see mm_cap_buf).
package mm_wr_capture_pkg;

  localparam int CAP_AW     = 32;
  localparam int CAP_LINE_W = 256;
  localparam int CAP_WORD_W = 32;
  localparam int WPL        = CAP_LINE_W / CAP_WORD_W;
  localparam int WIDX_W     = $clog2(WPL);
  localparam int LINE_SH    = $clog2(CAP_LINE_W / 8);
  localparam int WORD_SH    = $clog2(CAP_WORD_W / 8);

  typedef enum logic {
    IDLE   = 1'b0,
    SERIAL = 1'b1
  } cap_state_e;

  typedef struct packed {
    logic [CAP_AW-1:0]     addr;
    logic [CAP_WORD_W-1:0] data;
  } cap_entry_t;

endpackage

// File: rtl/mm_cap_buf.sv
// Capture buffer: DEPTH entries, write pointer, base, count, registered indexed read.
// MM_WR_CAPTURE_WRAP_EN makes it circular; otherwise writes stop when full.
module mm_cap_buf
  import mm_wr_capture_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  cap_entry_t               wr_ent,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output cap_entry_t               rd_ent,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     lost
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  cap_entry_t    mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] base_q, base_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cap_entry_t    rd_q, rd_d;
  logic          we;
  logic [PW-1:0] slot;

  assign full   = (cnt_q == CW'(DEPTH));
  assign lost   = wr_en & full;
  assign count  = cnt_q;
  assign rd_ent = rd_q;

  always_comb begin
    wptr_d = wptr_q;
    base_d = base_q;
    cnt_d  = cnt_q;
    we     = 1'b0;
`ifdef MM_WR_CAPTURE_WRAP_EN
    if (wr_en) begin
      we     = 1'b1;
      wptr_d = wptr_q + 1'b1;
      if (full) base_d = base_q + 1'b1;
      else      cnt_d  = cnt_q + 1'b1;
    end
`else
    if (wr_en && !full) begin
      we     = 1'b1;
      wptr_d = wptr_q + 1'b1;
      cnt_d  = cnt_q + 1'b1;
    end
`endif
    // Read sees pre-edge contents, so same-slot write returns old data
    slot = base_q + rd_idx;
    rd_d = ({1'b0, rd_idx} < cnt_q) ? mem_q[slot] : '0;
    if (clr) begin
      wptr_d = '0;
      base_d = '0;
      cnt_d  = '0;
      we     = 1'b0;
      rd_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      base_q <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
    end else begin
      wptr_q <= wptr_d;
      base_q <= base_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wptr_q] <= wr_ent;
  end

endmodule

// File: rtl/mm_wr_capture.sv
// Splits main-memory line writes into per-word capture entries with a one-line skid.
// Define MM_WR_CAPTURE_WRAP_EN for a circular capture buffer.
module mm_wr_capture
  import mm_wr_capture_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AW     = CAP_AW,
  parameter int LINE_W = CAP_LINE_W,
  parameter int WORD_W = CAP_WORD_W,
  parameter int DCW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mm_wr,
  input  logic [AW-1:0]            mm_a,
  input  logic [LINE_W-1:0]        mm_wd,
  input  logic                     cap_clr,
  input  logic [$clog2(DEPTH)-1:0] cap_rd_idx,
  output logic [AW-1:0]            cap_rd_addr,
  output logic [WORD_W-1:0]        cap_rd_data,
  output logic [$clog2(DEPTH):0]   cap_count,
  output logic                     cap_full,
  output logic                     cap_ovf,
  output logic [DCW-1:0]           cap_drop_cnt,
  output logic                     busy
);

  cap_state_e        state_q, state_d;
  logic [AW-1:0]     line_a_q, line_a_d;
  logic [LINE_W-1:0] line_w_q, line_w_d;
  logic [AW-1:0]     skid_a_q, skid_a_d;
  logic [LINE_W-1:0] skid_w_q, skid_w_d;
  logic              skid_v_q, skid_v_d;
  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [DCW-1:0]    drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic              last_w, promote, drop, wr_en, buf_lost;
  cap_entry_t        wr_ent, rd_ent;

  assign last_w  = (widx_q == WIDX_W'(WPL - 1));
  assign promote = (state_q == SERIAL) && last_w && skid_v_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (mm_wr) state_d = SERIAL;
      SERIAL: if (last_w && !skid_v_q && !mm_wr) state_d = IDLE;
    endcase
    if (cap_clr) state_d = IDLE;
  end

  always_comb begin
    wr_en = 1'b0;
    busy  = skid_v_q;
    unique case (state_q)
      IDLE:   ;
      SERIAL: begin
        wr_en = !cap_clr;
        busy  = 1'b1;
      end
    endcase
  end

  always_comb begin
    line_a_d = line_a_q;
    line_w_d = line_w_q;
    skid_a_d = skid_a_q;
    skid_w_d = skid_w_q;
    skid_v_d = skid_v_q;
    widx_d   = widx_q;
    drop     = 1'b0;
    if (state_q == IDLE) begin
      widx_d = '0;
      if (mm_wr) begin
        line_a_d = mm_a;
        line_w_d = mm_wd;
      end
    end else begin
      widx_d = widx_q + 1'b1;
      if (promote) begin
        line_a_d = skid_a_q;
        line_w_d = skid_w_q;
        skid_v_d = 1'b0;
      end
      // A line arriving on the last word with no skid chains straight in
      if (mm_wr) begin
        if (last_w && !skid_v_q) begin
          line_a_d = mm_a;
          line_w_d = mm_wd;
        end else if (!skid_v_q || promote) begin
          skid_a_d = mm_a;
          skid_w_d = mm_wd;
          skid_v_d = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    drop_d = (drop && drop_q != {DCW{1'b1}}) ? drop_q + 1'b1 : drop_q;
    ovf_d  = ovf_q | drop | buf_lost;
    if (cap_clr) begin
      skid_v_d = 1'b0;
      widx_d   = '0;
      drop_d   = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_a_q <= '0;
      line_w_q <= '0;
      skid_a_q <= '0;
      skid_w_q <= '0;
      skid_v_q <= 1'b0;
      widx_q   <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      line_a_q <= line_a_d;
      line_w_q <= line_w_d;
      skid_a_q <= skid_a_d;
      skid_w_q <= skid_w_d;
      skid_v_q <= skid_v_d;
      widx_q   <= widx_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wr_ent.addr = {line_a_q[AW-1:LINE_SH], widx_q, {WORD_SH{1'b0}}};
  assign wr_ent.data = line_w_q[widx_q*WORD_W +: WORD_W];

  mm_cap_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .clr    (cap_clr),
    .wr_en  (wr_en),
    .wr_ent (wr_ent),
    .rd_idx (cap_rd_idx),
    .rd_ent (rd_ent),
    .count  (cap_count),
    .full   (cap_full),
    .lost   (buf_lost)
  );

  assign cap_rd_addr  = rd_ent.addr;
  assign cap_rd_data  = rd_ent.data;
  assign cap_ovf      = ovf_q;
  assign cap_drop_cnt = drop_q;

endmodule

// File: tb/tb_mm_wr_capture.sv
// Scoreboard bench for mm_wr_capture; expected entries queued at stimulus time.
// Honours MM_WR_CAPTURE_WRAP_EN in its buffer model.
module tb_mm_wr_capture;
  import mm_wr_capture_pkg::*;

  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         mm_wr;
  logic [31:0]  mm_a;
  logic [255:0] mm_wd;
  logic         cap_clr;
  logic [3:0]   cap_rd_idx;
  logic [31:0]  cap_rd_addr;
  logic [31:0]  cap_rd_data;
  logic [4:0]   cap_count;
  logic         cap_full;
  logic         cap_ovf;
  logic [7:0]   cap_drop_cnt;
  logic         busy;

  int n_run  = 0;
  int n_fail = 0;
  cap_entry_t exp_q[$];

  mm_wr_capture dut (
    .clk          (clk),
    .rst          (rst),
    .mm_wr        (mm_wr),
    .mm_a         (mm_a),
    .mm_wd        (mm_wd),
    .cap_clr      (cap_clr),
    .cap_rd_idx   (cap_rd_idx),
    .cap_rd_addr  (cap_rd_addr),
    .cap_rd_data  (cap_rd_data),
    .cap_count    (cap_count),
    .cap_full     (cap_full),
    .cap_ovf      (cap_ovf),
    .cap_drop_cnt (cap_drop_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mkline(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = {a[15:0], 8'hC5, 8'(i)};
    return l;
  endfunction

  // Buffer model: stop-when-full, or drop-oldest when circular
  function automatic void push_exp(input cap_entry_t e);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else begin
`ifdef MM_WR_CAPTURE_WRAP_EN
      exp_q.delete(0);
      exp_q.push_back(e);
`endif
    end
  endfunction

  task automatic issue(input logic [31:0] a, input logic [255:0] d, input bit keep);
    cap_entry_t e;
    mm_wr = 1'b1;
    mm_a  = a;
    mm_wd = d;
    if (keep) begin
      for (int i = 0; i < 8; i++) begin
        e.addr = {a[31:5], 3'(i), 2'b00};
        e.data = d[32*i +: 32];
        push_exp(e);
      end
    end
    cyc();
    mm_wr = 1'b0;
  endtask

  task automatic rd(input int idx, output logic [31:0] a, output logic [31:0] d);
    cap_rd_idx = idx[3:0];
    cyc();
    a = cap_rd_addr;
    d = cap_rd_data;
  endtask

  task automatic do_clr();
    cap_clr = 1'b1;
    cyc();
    cap_clr = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; mm_wr = 1'b0; mm_a = '0; mm_wd = '0; cap_clr = 1'b0; cap_rd_idx = '0;
    #12;
    n_run++; if (cap_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", cap_count); end
    n_run++; if ({cap_full, cap_ovf, busy} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {cap_full, cap_ovf, busy}); end
    n_run++; if (cap_drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", cap_drop_cnt); end
    n_run++; if ({cap_rd_addr, cap_rd_data} !== 64'd0) begin n_fail++; $display("FAIL reset_rd got %h want 0", {cap_rd_addr, cap_rd_data}); end
    @(negedge clk);
    rst = 1'b0;
    cyc();
    cyc();
    n_run++; if ({cap_count, busy, cap_rd_data} !== 38'd0) begin n_fail++; $display("FAIL post_reset got %h want 0", {cap_count, busy, cap_rd_data}); end
  endtask

  task automatic test_single_line();
    logic [31:0] ra, rdd;
    cap_entry_t e;
    do_clr();
    issue(32'h0000_0047, 256'h00000088_00000077_00000066_00000055_00000044_00000033_00000022_00000011, 1'b1);
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_T1 got %b want 1", busy); end
    repeat (7) cyc();
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_T8 got %b want 1", busy); end
    cyc();
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_T9 got %b want 0", busy); end
    n_run++; if (cap_count !== 5'd8) begin n_fail++; $display("FAIL single_count got %0d want 8", cap_count); end
    n_run++; if (cap_full !== 1'b0) begin n_fail++; $display("FAIL single_full got %b want 0", cap_full); end
    for (int i = 0; i < 8; i++) begin
      rd(i, ra, rdd);
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      n_run++;
      if (ra !== e.addr || rdd !== e.data) begin
        n_fail++; $display("FAIL single_idx%0d got %h/%h want %h/%h", i, ra, rdd, e.addr, e.data);
      end
    end
    rd(8, ra, rdd);
    n_run++; if ({ra, rdd} !== 64'd0) begin n_fail++; $display("FAIL single_idx8_empty got %h/%h want 0/0", ra, rdd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ra, rdd;
    cap_entry_t e;
    do_clr();
    issue(32'h100, mkline(32'h100), 1'b1);
    issue(32'h200, mkline(32'h200), 1'b1);
    issue(32'h300, mkline(32'h300), 1'b0);
    n_run++; if (cap_drop_cnt !== 8'd1) begin n_fail++; $display("FAIL b2b_drop got %0d want 1", cap_drop_cnt); end
    n_run++; if (cap_ovf !== 1'b1) begin n_fail++; $display("FAIL b2b_ovf got %b want 1", cap_ovf); end
    repeat (14) cyc();
    n_run++; if (cap_count !== 5'd16) begin n_fail++; $display("FAIL b2b_count got %0d want 16", cap_count); end
    n_run++; if ({cap_full, busy} !== 2'b10) begin n_fail++; $display("FAIL b2b_full_busy got %b want 10", {cap_full, busy}); end
    for (int i = 0; i < 16; i++) begin
      rd(i, ra, rdd);
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      n_run++;
      if (ra !== e.addr || rdd !== e.data) begin
        n_fail++; $display("FAIL b2b_idx%0d got %h/%h want %h/%h", i, ra, rdd, e.addr, e.data);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] ra, rdd;
    cap_entry_t e;
    do_clr();
    issue(32'h000, mkline(32'h000), 1'b1);
    repeat (9) cyc();
    issue(32'h020, mkline(32'h020), 1'b1);
    repeat (9) cyc();
    issue(32'h040, mkline(32'h040), 1'b1);
    repeat (8) cyc();
    n_run++; if (cap_count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got %0d want 16", cap_count); end
    n_run++; if ({cap_full, cap_ovf, busy} !== 3'b110) begin n_fail++; $display("FAIL ovf_flags got %b want 110", {cap_full, cap_ovf, busy}); end
    n_run++; if (cap_drop_cnt !== 8'd0) begin n_fail++; $display("FAIL ovf_drop got %0d want 0", cap_drop_cnt); end
    for (int i = 0; i < 16; i++) begin
      rd(i, ra, rdd);
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      n_run++;
      if (ra !== e.addr || rdd !== e.data) begin
        n_fail++; $display("FAIL ovf_idx%0d got %h/%h want %h/%h", i, ra, rdd, e.addr, e.data);
      end
    end
  endtask

  task automatic test_promote();
    logic [31:0] ra, rdd;
    cap_entry_t e;
    do_clr();
    issue(32'h700, mkline(32'h700), 1'b1);
    issue(32'h740, mkline(32'h740), 1'b1);
    repeat (6) cyc();
    issue(32'h780, mkline(32'h780), 1'b1);
    n_run++; if (cap_drop_cnt !== 8'd0) begin n_fail++; $display("FAIL promote_drop got %0d want 0", cap_drop_cnt); end
    repeat (15) cyc();
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL promote_busy_T24 got %b want 1", busy); end
    cyc();
    n_run++; if ({busy, cap_ovf, cap_count} !== {1'b0, 1'b1, 5'd16}) begin n_fail++; $display("FAIL promote_end got %b/%b/%0d want 0/1/16", busy, cap_ovf, cap_count); end
    for (int i = 0; i < 16; i++) begin
      rd(i, ra, rdd);
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      n_run++;
      if (ra !== e.addr || rdd !== e.data) begin
        n_fail++; $display("FAIL promote_idx%0d got %h/%h want %h/%h", i, ra, rdd, e.addr, e.data);
      end
    end
  endtask

  task automatic test_clr();
    logic [31:0] ra, rdd;
    do_clr();
    issue(32'h400, mkline(32'h400), 1'b1);
    issue(32'h440, mkline(32'h440), 1'b1);
    issue(32'h480, mkline(32'h480), 1'b0);
    cyc();
    n_run++; if (cap_count !== 5'd3) begin n_fail++; $display("FAIL clr_pre_count got %0d want 3", cap_count); end
    n_run++; if (cap_drop_cnt !== 8'd1) begin n_fail++; $display("FAIL clr_pre_drop got %0d want 1", cap_drop_cnt); end
    cap_clr = 1'b1; mm_wr = 1'b1; mm_a = 32'h4C0; mm_wd = mkline(32'h4C0);
    cyc();
    cap_clr = 1'b0; mm_wr = 1'b0;
    exp_q.delete();
    n_run++; if ({cap_count, busy, cap_ovf} !== 7'd0) begin n_fail++; $display("FAIL clr_state got %h want 0", {cap_count, busy, cap_ovf}); end
    n_run++; if (cap_drop_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_drop got %0d want 0", cap_drop_cnt); end
    repeat (20) cyc();
    n_run++; if ({cap_count, busy} !== 6'd0) begin n_fail++; $display("FAIL clr_quiet got %h want 0", {cap_count, busy}); end
    rd(0, ra, rdd);
    n_run++; if ({ra, rdd} !== 64'd0) begin n_fail++; $display("FAIL clr_rd0 got %h/%h want 0/0", ra, rdd); end
  endtask

  task automatic test_async_rst();
    logic [31:0] ra, rdd;
    logic [255:0] l;
    cap_entry_t e;
    do_clr();
    cap_rd_idx = '0;
    l = mkline(32'h500);
    issue(32'h500, l, 1'b0);
    repeat (5) cyc();
    n_run++; if (cap_count !== 5'd5) begin n_fail++; $display("FAIL arst_pre_count got %0d want 5", cap_count); end
    n_run++; if (cap_rd_data !== l[31:0]) begin n_fail++; $display("FAIL arst_pre_rd got %h want %h", cap_rd_data, l[31:0]); end
    #3 rst = 1'b1;
    #1;
    n_run++; if ({cap_count, busy, cap_ovf, cap_full} !== 8'd0) begin n_fail++; $display("FAIL arst_now got %h want 0", {cap_count, busy, cap_ovf, cap_full}); end
    n_run++; if ({cap_rd_addr, cap_rd_data} !== 64'd0) begin n_fail++; $display("FAIL arst_rd got %h want 0", {cap_rd_addr, cap_rd_data}); end
    #2 rst = 1'b0;
    cyc();
    exp_q.delete();
    issue(32'h600, mkline(32'h600), 1'b1);
    repeat (8) cyc();
    n_run++; if ({cap_count, busy} !== {5'd8, 1'b0}) begin n_fail++; $display("FAIL arst_after got %0d/%b want 8/0", cap_count, busy); end
    for (int i = 0; i < 8; i++) begin
      rd(i, ra, rdd);
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      n_run++;
      if (ra !== e.addr || rdd !== e.data) begin
        n_fail++; $display("FAIL arst_idx%0d got %h/%h want %h/%h", i, ra, rdd, e.addr, e.data);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_line();
    test_back_to_back();
    test_overflow();
    test_promote();
    test_clr();
    test_async_rst();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
